// File: rtl/wfq_pkg.sv
// Shared widths, packet descriptor and read-FSM state encoding for the WFQ
// ingress packetizer.
package wfq_pkg;

  localparam int WFQ_DATA_BITWIDTH = 64;
  localparam int WFQ_LEN_BITWIDTH  = 9;
  localparam int WFQ_FLOWID_BITWIDTH = 13;
  localparam int WFQ_DATA_FIFO_AW  = 9;

  typedef struct packed {
    logic [WFQ_LEN_BITWIDTH-1:0]    len;
    logic [WFQ_FLOWID_BITWIDTH-1:0] flow_id;
    logic [WFQ_DATA_FIFO_AW-1:0]    start_addr;
  } desc_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_BURST,
    RD_GAP
  } rd_state_e;

endpackage

// File: rtl/wfq_sync_ram_1r1w.sv
// Simple dual-port data store: one write port, one read port with a registered
// read (data appears the cycle after the address).
module wfq_sync_ram_1r1w #(
  parameter int DW = 64,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wfq_ingress_packetizer.sv
// Store-and-forward packetizer: buffers each upstream packet whole, then replays
// it as one packet_arrival pulse plus a contiguous data_arrival burst.
module wfq_ingress_packetizer
  import wfq_pkg::*;
#(
  parameter int PACKET_DATA_BITWIDTH = WFQ_DATA_BITWIDTH,
  parameter int PACKET_LEN_BITWIDTH  = WFQ_LEN_BITWIDTH,
  parameter int FLOWID_BITWIDTH      = WFQ_FLOWID_BITWIDTH,
  parameter int DATA_FIFO_AW         = WFQ_DATA_FIFO_AW,
  parameter int DESC_FIFO_AW         = 3,
  parameter int MIN_GAP              = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [PACKET_DATA_BITWIDTH-1:0] s_data,
  input  logic                            s_last,
  input  logic [FLOWID_BITWIDTH-1:0]      s_flow_id,
  input  logic                            in_downstream_full,
  output logic                            out_packet_arrival,
  output logic                            out_data_arrival,
  output logic [PACKET_LEN_BITWIDTH-1:0]  out_packet_length,
  output logic [FLOWID_BITWIDTH-1:0]      out_flow_id,
  output logic [PACKET_DATA_BITWIDTH-1:0] out_packet_data,
  output logic [15:0]                     out_drop_count,
  output logic [15:0]                     out_pkt_count
);

  localparam int DESC_DEPTH = 1 << DESC_FIFO_AW;
  localparam logic [PACKET_LEN_BITWIDTH-1:0] MAX_LEN = '1;

  logic [DATA_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d;
  logic [DATA_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, rd_addr_q, rd_addr_d, ram_rd_addr;
  logic [PACKET_LEN_BITWIDTH-1:0] len_q, len_d, sent_q, sent_d;
  logic [FLOWID_BITWIDTH-1:0] flow_tmp_q, flow_tmp_d;
  logic discard_q, discard_d;
  logic [15:0] drop_q, drop_d, pkt_q, pkt_d;

  desc_t desc_mem [DESC_DEPTH];
  desc_t push_desc, head_desc, cur_q, cur_d;
  logic [DESC_FIFO_AW:0] dwr_q, dwr_d, drd_q, drd_d;
  logic push, pop, desc_empty, desc_full, ram_full, accept, ram_we;

  rd_state_e state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic pa_q, pa_d, da_q, da_d;
  logic [PACKET_LEN_BITWIDTH-1:0]  olen_q, olen_d;
  logic [FLOWID_BITWIDTH-1:0]      oflow_q, oflow_d;
  logic [PACKET_DATA_BITWIDTH-1:0] odata_q, odata_d, ram_rdata;

  assign desc_empty = (dwr_q == drd_q);
  assign desc_full  = (dwr_q[DESC_FIFO_AW] != drd_q[DESC_FIFO_AW]) &&
                      (dwr_q[DESC_FIFO_AW-1:0] == drd_q[DESC_FIFO_AW-1:0]);
  assign head_desc  = desc_mem[drd_q[DESC_FIFO_AW-1:0]];
  // One RAM slot stays empty so full and empty pointers never coincide.
  assign ram_full   = ((wr_tmp_q + DATA_FIFO_AW'(1)) == rd_ptr_q);

  // A word that will make the packet oversize is never written, so it must not
  // wait for RAM space; otherwise a max-size packet could deadlock.
  assign s_ready = !rst && (discard_q || (len_q == MAX_LEN) ||
                            (!ram_full && !(s_last && desc_full)));
  assign accept  = s_valid && s_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_tmp_d   = wr_tmp_q;
    len_d      = len_q;
    flow_tmp_d = flow_tmp_q;
    discard_d  = discard_q;
    drop_d     = drop_q;
    ram_we     = 1'b0;
    push       = 1'b0;
    push_desc.len        = len_q + PACKET_LEN_BITWIDTH'(1);
    push_desc.flow_id    = (len_q == '0) ? s_flow_id : flow_tmp_q;
    push_desc.start_addr = wr_ptr_q;
    if (accept) begin
      if (discard_q) begin
        if (s_last) discard_d = 1'b0;
      end else if (len_q == MAX_LEN) begin
        wr_tmp_d  = wr_ptr_q;
        len_d     = '0;
        discard_d = !s_last;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else begin
        ram_we   = 1'b1;
        wr_tmp_d = wr_tmp_q + DATA_FIFO_AW'(1);
        if (len_q == '0) flow_tmp_d = s_flow_id;
        if (s_last) begin
          push     = 1'b1;
          wr_ptr_d = wr_tmp_q + DATA_FIFO_AW'(1);
          len_d    = '0;
        end else begin
          len_d = len_q + PACKET_LEN_BITWIDTH'(1);
        end
      end
    end
  end

  // Read side: IDLE pops and addresses word 0, FETCH addresses word 1 while
  // word 0 lands in the output register, BURST streams one word per cycle.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cur_d       = cur_q;
    rd_addr_d   = rd_addr_q;
    ram_rd_addr = rd_addr_q;
    sent_d      = sent_q;
    gap_d       = gap_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_d       = pkt_q;
    pa_d        = 1'b0;
    da_d        = 1'b0;
    olen_d      = olen_q;
    oflow_d     = oflow_q;
    odata_d     = odata_q;
    case (state_q)
      RD_IDLE: begin
        if (!desc_empty && !in_downstream_full) begin
          pop         = 1'b1;
          cur_d       = head_desc;
          ram_rd_addr = head_desc.start_addr;
          rd_addr_d   = head_desc.start_addr + DATA_FIFO_AW'(1);
          state_d     = RD_FETCH;
        end
      end
      RD_FETCH: begin
        pa_d      = 1'b1;
        da_d      = 1'b1;
        odata_d   = ram_rdata;
        olen_d    = cur_q.len;
        oflow_d   = cur_q.flow_id;
        sent_d    = PACKET_LEN_BITWIDTH'(1);
        rd_addr_d = rd_addr_q + DATA_FIFO_AW'(1);
        state_d   = RD_BURST;
      end
      RD_BURST: begin
        if (sent_q == cur_q.len) begin
          rd_ptr_d = rd_ptr_q + DATA_FIFO_AW'(cur_q.len);
          pkt_d    = pkt_q + 16'd1;
          gap_d    = '0;
          state_d  = (MIN_GAP == 0) ? RD_IDLE : RD_GAP;
        end else begin
          da_d      = 1'b1;
          odata_d   = ram_rdata;
          sent_d    = sent_q + PACKET_LEN_BITWIDTH'(1);
          rd_addr_d = rd_addr_q + DATA_FIFO_AW'(1);
        end
      end
      RD_GAP: begin
        if (gap_q == 8'(MIN_GAP - 1)) state_d = RD_IDLE;
        else                          gap_d   = gap_q + 8'd1;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign dwr_d = dwr_q + (DESC_FIFO_AW+1)'(push);
  assign drd_d = drd_q + (DESC_FIFO_AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      wr_tmp_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      discard_q <= 1'b0;
      drop_q    <= '0;
      pkt_q     <= '0;
      dwr_q     <= '0;
      drd_q     <= '0;
      state_q   <= RD_IDLE;
      sent_q    <= '0;
      gap_q     <= '0;
      pa_q      <= 1'b0;
      da_q      <= 1'b0;
      olen_q    <= '0;
      oflow_q   <= '0;
      odata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_tmp_q  <= wr_tmp_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      discard_q <= discard_d;
      drop_q    <= drop_d;
      pkt_q     <= pkt_d;
      dwr_q     <= dwr_d;
      drd_q     <= drd_d;
      state_q   <= state_d;
      sent_q    <= sent_d;
      gap_q     <= gap_d;
      pa_q      <= pa_d;
      da_q      <= da_d;
      olen_q    <= olen_d;
      oflow_q   <= oflow_d;
      odata_q   <= odata_d;
    end
  end

  always_ff @(posedge clk) begin
    flow_tmp_q <= flow_tmp_d;
    cur_q      <= cur_d;
    rd_addr_q  <= rd_addr_d;
    if (push) desc_mem[dwr_q[DESC_FIFO_AW-1:0]] <= push_desc;
  end

  wfq_sync_ram_1r1w #(
    .DW(PACKET_DATA_BITWIDTH),
    .AW(DATA_FIFO_AW)
  ) u_data_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(wr_tmp_q),
    .wr_data(s_data),
    .rd_addr(ram_rd_addr),
    .rd_data(ram_rdata)
  );

  assign out_packet_arrival = pa_q;
  assign out_data_arrival   = da_q;
  assign out_packet_length  = olen_q;
  assign out_flow_id        = oflow_q;
  assign out_packet_data    = odata_q;
  assign out_drop_count     = drop_q;
  assign out_pkt_count      = pkt_q;

endmodule

// File: tb/tb_wfq_ingress_packetizer.sv
// Directed bench for wfq_ingress_packetizer: scenario tasks compare captured
// output bursts against hand-computed timing, lengths, flow ids and data.
module tb_wfq_ingress_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last, in_downstream_full;
  logic [63:0] s_data;
  logic [12:0] s_flow_id;
  logic        out_packet_arrival, out_data_arrival;
  logic [8:0]  out_packet_length;
  logic [12:0] out_flow_id;
  logic [63:0] out_packet_data;
  logic [15:0] out_drop_count, out_pkt_count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int          wcyc[$];
  logic [63:0] wdat[$];
  int          pcyc[$];
  int          plen[$];
  int          pflow[$];

  wfq_ingress_packetizer dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .s_flow_id         (s_flow_id),
    .in_downstream_full(in_downstream_full),
    .out_packet_arrival(out_packet_arrival),
    .out_data_arrival  (out_data_arrival),
    .out_packet_length (out_packet_length),
    .out_flow_id       (out_flow_id),
    .out_packet_data   (out_packet_data),
    .out_drop_count    (out_drop_count),
    .out_pkt_count     (out_pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_data_arrival === 1'b1) begin
      wcyc.push_back(cyc);
      wdat.push_back(out_packet_data);
    end
    if (out_packet_arrival === 1'b1) begin
      pcyc.push_back(cyc);
      plen.push_back(int'(out_packet_length));
      pflow.push_back(int'(out_flow_id));
    end
  end

  task automatic clear_capture();
    wcyc.delete(); wdat.delete(); pcyc.delete(); plen.delete(); pflow.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Flow id is only valid on the first word; later words carry its complement
  // so a design that resamples it gets caught.
  task automatic send_pkt(input int len, input int flow, input logic [63:0] base,
                          output int first_acc, output int last_acc, output int stalls);
    int guard;
    bit done;
    stalls = 0; first_acc = -1; last_acc = -1;
    for (int i = 0; i < len; i++) begin
      s_valid   = 1'b1;
      s_data    = base + 64'(i);
      s_last    = (i == len - 1);
      s_flow_id = (i == 0) ? flow[12:0] : ~flow[12:0];
      done = 1'b0; guard = 0;
      while (!done) begin
        @(negedge clk);
        if (s_ready === 1'b1) begin
          done = 1'b1;
          if (i == 0) first_acc = cyc;
          if (i == len - 1) last_acc = cyc;
        end else begin
          stalls++; guard++;
        end
        @(posedge clk); #1;
        if (guard > 2000) begin
          n_vec++; n_bad++;
          $display("FAIL send_timeout: word %0d of %0d never accepted", i, len);
          s_valid = 1'b0; s_last = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_flow_id = '0;
    in_downstream_full = 1'b0;
    idle(3);
    @(negedge clk);
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
    n_vec++; if ({out_packet_arrival, out_data_arrival, out_packet_length, out_flow_id, out_packet_data} !== '0) begin
      n_bad++; $display("FAIL rst_outputs: got pa=%b da=%b len=%0d flow=%0d data=%0h want all 0",
                        out_packet_arrival, out_data_arrival, out_packet_length, out_flow_id, out_packet_data); end
    n_vec++; if (out_drop_count !== 16'd0) begin n_bad++; $display("FAIL rst_drop: got %0d want 0", out_drop_count); end
    n_vec++; if (out_pkt_count !== 16'd0) begin n_bad++; $display("FAIL rst_pkt: got %0d want 0", out_pkt_count); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", s_ready); end
    idle(1);
  endtask

  task automatic test_single();
    int fa, la, st, bad;
    clear_capture();
    send_pkt(4, 5, 64'h1, fa, la, st);
    idle(12);
    n_vec++; if (pcyc.size() !== 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", pcyc.size()); end
    else begin
      n_vec++; if (pcyc[0] !== la + 3) begin n_bad++; $display("FAIL single_latency: got cyc %0d want %0d", pcyc[0], la + 3); end
      n_vec++; if (plen[0] !== 4) begin n_bad++; $display("FAIL single_len: got %0d want 4", plen[0]); end
      n_vec++; if (pflow[0] !== 5) begin n_bad++; $display("FAIL single_flow: got %0d want 5", pflow[0]); end
    end
    n_vec++; if (wdat.size() !== 4) begin n_bad++; $display("FAIL single_words: got %0d want 4", wdat.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 4; i++)
        if (wdat[i] !== 64'(i + 1) || wcyc[i] !== la + 3 + i) bad++;
      n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL single_data: got %0d bad words want 0", bad); end
    end
    n_vec++; if (out_pkt_count !== 16'd1) begin n_bad++; $display("FAIL single_pkt_count: got %0d want 1", out_pkt_count); end
  endtask

  // Pop-to-pop period is L + 2 + MIN_GAP: IDLE, FETCH, L burst cycles, GAP.
  task automatic test_back_to_back();
    int fa, la, st;
    clear_capture();
    send_pkt(1, 7, 64'hA, fa, la, st);
    send_pkt(1, 8, 64'hB, fa, la, st);
    idle(12);
    n_vec++; if (pcyc.size() !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pcyc.size()); end
    else begin
      n_vec++; if (pcyc[1] - pcyc[0] !== 4) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 4", pcyc[1] - pcyc[0]); end
      n_vec++; if (pflow[1] !== 8 || plen[1] !== 1) begin n_bad++; $display("FAIL b2b_desc: got flow %0d len %0d want 8 1", pflow[1], plen[1]); end
    end
    n_vec++; if (wdat.size() !== 2) begin n_bad++; $display("FAIL b2b_words: got %0d want 2", wdat.size()); end
    else begin
      n_vec++; if (wdat[0] !== 64'hA || wdat[1] !== 64'hB) begin n_bad++; $display("FAIL b2b_data: got %0h %0h want a b", wdat[0], wdat[1]); end
    end
  endtask

  task automatic test_oversize();
    int fa, la, st;
    clear_capture();
    send_pkt(512, 3, 64'h9000, fa, la, st);
    idle(10);
    n_vec++; if (st !== 0) begin n_bad++; $display("FAIL ovs512_stalls: got %0d want 0", st); end
    n_vec++; if (out_drop_count !== 16'd1) begin n_bad++; $display("FAIL ovs512_drop: got %0d want 1", out_drop_count); end
    n_vec++; if (wdat.size() !== 0) begin n_bad++; $display("FAIL ovs512_output: got %0d words want 0", wdat.size()); end
    send_pkt(520, 6, 64'hA000, fa, la, st);
    idle(10);
    n_vec++; if (st !== 0 || out_drop_count !== 16'd2) begin
      n_bad++; $display("FAIL ovs520: got stalls %0d drop %0d want 0 2", st, out_drop_count); end
    send_pkt(3, 9, 64'h100, fa, la, st);
    idle(12);
    n_vec++; if (pcyc.size() !== 1 || wdat.size() !== 3) begin
      n_bad++; $display("FAIL ovs_follow_count: got %0d pulses %0d words want 1 3", pcyc.size(), wdat.size()); end
    else begin
      n_vec++; if (plen[0] !== 3 || pflow[0] !== 9 || wdat[0] !== 64'h100 || wdat[1] !== 64'h101 || wdat[2] !== 64'h102) begin
        n_bad++; $display("FAIL ovs_follow_pkt: got len %0d flow %0d data %0h %0h %0h want 3 9 100 101 102",
                          plen[0], pflow[0], wdat[0], wdat[1], wdat[2]); end
    end
    n_vec++; if (out_pkt_count !== 16'd4) begin n_bad++; $display("FAIL ovs_pkt_count: got %0d want 4", out_pkt_count); end
  endtask

  task automatic test_downstream_full();
    int fa, la, st, d, e, bad;
    clear_capture();
    in_downstream_full = 1'b1;
    send_pkt(3, 2, 64'h30, fa, la, st);
    send_pkt(2, 1, 64'h20, fa, la, st);
    idle(10);
    n_vec++; if (pcyc.size() !== 0 || wdat.size() !== 0) begin
      n_bad++; $display("FAIL full_hold: got %0d pulses %0d words want 0 0", pcyc.size(), wdat.size()); end
    in_downstream_full = 1'b0; d = cyc;
    idle(3);
    in_downstream_full = 1'b1;
    idle(12);
    n_vec++; if (pcyc.size() !== 1) begin n_bad++; $display("FAIL full_first_pulses: got %0d want 1", pcyc.size()); end
    else begin
      n_vec++; if (pcyc[0] !== d + 2) begin n_bad++; $display("FAIL full_release_latency: got cyc %0d want %0d", pcyc[0], d + 2); end
    end
    n_vec++; if (wdat.size() !== 3) begin n_bad++; $display("FAIL full_midburst_words: got %0d want 3", wdat.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 3; i++)
        if (wdat[i] !== 64'(8'h30 + i) || wcyc[i] !== d + 2 + i) bad++;
      n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL full_midburst_data: got %0d bad words want 0", bad); end
    end
    in_downstream_full = 1'b0; e = cyc;
    idle(10);
    n_vec++; if (pcyc.size() !== 2) begin n_bad++; $display("FAIL full_second_pulses: got %0d want 2", pcyc.size()); end
    else begin
      n_vec++; if (pcyc[1] !== e + 2 || plen[1] !== 2 || pflow[1] !== 1) begin
        n_bad++; $display("FAIL full_second_pkt: got cyc %0d len %0d flow %0d want %0d 2 1", pcyc[1], plen[1], pflow[1], e + 2); end
    end
  endtask

  // The 511-word packet fills every usable RAM slot and wraps past the end;
  // the next packet cannot start until that burst frees the space.
  task automatic test_ram_wrap();
    int fa, la, st, fa2, la2, st2, bad;
    clear_capture();
    send_pkt(511, 12'h7AB, 64'h1000, fa, la, st);
    send_pkt(5, 12'h123, 64'h2000, fa2, la2, st2);
    idle(30);
    n_vec++; if (st !== 0) begin n_bad++; $display("FAIL wrap_first_stalls: got %0d want 0", st); end
    n_vec++; if (fa2 !== la + 514) begin n_bad++; $display("FAIL wrap_resume_cyc: got %0d want %0d", fa2, la + 514); end
    n_vec++; if (st2 !== 513) begin n_bad++; $display("FAIL wrap_stall_cycles: got %0d want 513", st2); end
    n_vec++; if (wdat.size() !== 516 || pcyc.size() !== 2) begin
      n_bad++; $display("FAIL wrap_counts: got %0d words %0d pulses want 516 2", wdat.size(), pcyc.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 511; i++)
        if (wdat[i] !== 64'h1000 + 64'(i) || wcyc[i] !== la + 3 + i) bad++;
      n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL wrap_data: got %0d bad words want 0", bad); end
      n_vec++; if (plen[0] !== 511 || pflow[0] !== 12'h7AB) begin
        n_bad++; $display("FAIL wrap_desc: got len %0d flow %0h want 511 7ab", plen[0], pflow[0]); end
      bad = 0;
      for (int i = 0; i < 5; i++)
        if (wdat[511 + i] !== 64'h2000 + 64'(i)) bad++;
      n_vec++; if (bad !== 0 || plen[1] !== 5 || pflow[1] !== 12'h123) begin
        n_bad++; $display("FAIL wrap_second: got %0d bad words len %0d flow %0h want 0 5 123", bad, plen[1], pflow[1]); end
    end
    n_vec++; if (out_pkt_count !== 16'd8) begin n_bad++; $display("FAIL wrap_pkt_count: got %0d want 8", out_pkt_count); end
  endtask

  task automatic test_reset_mid_burst();
    int fa, la, st, nw;
    bit seen;
    clear_capture();
    send_pkt(10, 4, 64'h50, fa, la, st);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pcyc.size() != 0) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL rstmid_no_pulse: got none want 1 within 50 cycles"); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", s_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    nw = wdat.size();
    n_vec++; if ({out_packet_arrival, out_data_arrival, out_packet_length, out_flow_id, out_packet_data} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got da=%b len=%0d flow=%0d data=%0h want all 0",
                        out_data_arrival, out_packet_length, out_flow_id, out_packet_data); end
    n_vec++; if (out_pkt_count !== 16'd0 || out_drop_count !== 16'd0) begin
      n_bad++; $display("FAIL rstmid_counters: got pkt %0d drop %0d want 0 0", out_pkt_count, out_drop_count); end
    idle(20);
    n_vec++; if (wdat.size() !== nw || nw >= 10) begin
      n_bad++; $display("FAIL rstmid_no_more_words: got %0d then %0d words want unchanged and <10", nw, wdat.size()); end
    n_vec++; if (pcyc.size() !== 1) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 1", pcyc.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_oversize();
    test_downstream_full();
    test_ram_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
